// File: rtl/conv_win_addr_gen_if.sv
// Read-address bus between the sliding-window address generator and the
// MAC/pool datapath that consumes the addresses.
//   addr      : LANES packed addresses, lane l at [l*ADDR_W +: ADDR_W]
//   valid     : addr holds a live tap
//   ready     : consumer accepts the current addresses this cycle
//   tap_first : tap (0,0) of a window
//   tap_last  : tap (K-1,K-1) of a window
//   row_last  : window is the last one of its output row
// master = address generator, slave = consumer.
interface conv_win_addr_gen_if #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 10
);
  logic [LANES*ADDR_W-1:0] addr;
  logic                    valid;
  logic                    ready;
  logic                    tap_first;
  logic                    tap_last;
  logic                    row_last;

  modport master (
    output addr, valid, tap_first, tap_last, row_last,
    input  ready
  );

  modport slave (
    input  addr, valid, tap_first, tap_last, row_last,
    output ready
  );
endinterface

// File: rtl/conv_win_addr_gen.sv
// Read-address generator for sliding-window layers (conv taps / pool windows)
// over a row-major image memory. Each transfer carries LANES addresses, one
// per horizontal band of OUT_H/LANES output rows.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high
//   start  : one-cycle request to begin a pass, honoured only in IDLE
//   bus    : address/handshake bus (master side)
//   busy   : pass in progress
//   done   : one-cycle pulse after the final transfer
//
// state  | meaning
// IDLE   | waiting for start, outputs quiet
// RUN    | presenting taps, advancing on valid && ready
// DONE   | one-cycle done pulse, then back to IDLE
module conv_win_addr_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int LANES  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  conv_win_addr_gen_if.master bus,
  output logic                busy,
  output logic                done
);

  localparam int OUT_W     = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H     = (IMG_H - K) / STRIDE + 1;
  localparam int RPL       = OUT_H / LANES;
  localparam int LANE_STEP = RPL * STRIDE * IMG_W;

  localparam int KW  = (K > 1)     ? $clog2(K)     : 1;
  localparam int OXW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OYW = (RPL > 1)   ? $clog2(RPL)   : 1;

  // Address step for each counter that can be the one advancing; lower
  // counters wrap back to 0 in the same step, hence the subtracted spans.
  localparam int D_KC = 1;
  localparam int D_KR = IMG_W - (K - 1);
  localparam int D_OX = STRIDE - (K - 1) * IMG_W - (K - 1);
  localparam int D_OY = STRIDE * IMG_W - (K - 1) * IMG_W - (K - 1) - (OUT_W - 1) * STRIDE;

  if ((IMG_W - K) % STRIDE != 0) begin : g_bad_w
    $error("conv_win_addr_gen: (IMG_W-K) not a multiple of STRIDE");
  end
  if ((IMG_H - K) % STRIDE != 0) begin : g_bad_h
    $error("conv_win_addr_gen: (IMG_H-K) not a multiple of STRIDE");
  end
  if (OUT_H % LANES != 0) begin : g_bad_lanes
    $error("conv_win_addr_gen: OUT_H not a multiple of LANES");
  end
  if ((64'd1 << ADDR_W) < 64'(IMG_W * IMG_H)) begin : g_bad_aw
    $error("conv_win_addr_gen: ADDR_W too small for IMG_W*IMG_H");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state;
  logic [KW-1:0]           kc, kr, kc_n, kr_n;
  logic [OXW-1:0]          ox, ox_n;
  logic [OYW-1:0]          oy, oy_n;
  logic [LANES*ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0]       delta;
  logic                    valid_q, first_q, last_q, rowl_q, busy_q, done_q;
  logic                    kc_max, kr_max, ox_max, oy_max, final_xfer;

  assign bus.addr      = addr_q;
  assign bus.valid     = valid_q;
  assign bus.tap_first = first_q;
  assign bus.tap_last  = last_q;
  assign bus.row_last  = rowl_q;
  assign busy          = busy_q;
  assign done          = done_q;

  always_comb begin
    kc_max     = (kc == KW'(K - 1));
    kr_max     = (kr == KW'(K - 1));
    ox_max     = (ox == OXW'(OUT_W - 1));
    oy_max     = (oy == OYW'(RPL - 1));
    final_xfer = kc_max && kr_max && ox_max && oy_max;
    kc_n  = kc;
    kr_n  = kr;
    ox_n  = ox;
    oy_n  = oy;
    delta = '0;
    if (!kc_max) begin
      kc_n  = kc + KW'(1);
      delta = ADDR_W'(D_KC);
    end else if (!kr_max) begin
      kc_n  = '0;
      kr_n  = kr + KW'(1);
      delta = ADDR_W'(D_KR);
    end else if (!ox_max) begin
      kc_n  = '0;
      kr_n  = '0;
      ox_n  = ox + OXW'(1);
      delta = ADDR_W'(D_OX);
    end else begin
      kc_n  = '0;
      kr_n  = '0;
      ox_n  = '0;
      oy_n  = oy + OYW'(1);
      delta = ADDR_W'(D_OY);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      kc      <= '0;
      kr      <= '0;
      ox      <= '0;
      oy      <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      rowl_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state   <= S_RUN;
            kc      <= '0;
            kr      <= '0;
            ox      <= '0;
            oy      <= '0;
            for (int l = 0; l < LANES; l++)
              addr_q[l*ADDR_W +: ADDR_W] <= ADDR_W'(l * LANE_STEP);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            first_q <= 1'b1;
            last_q  <= (K == 1);
            rowl_q  <= (OUT_W == 1);
          end
        end
        S_RUN: begin
          if (valid_q && bus.ready) begin
            if (final_xfer) begin
              state   <= S_DONE;
              kc      <= '0;
              kr      <= '0;
              ox      <= '0;
              oy      <= '0;
              addr_q  <= '0;
              valid_q <= 1'b0;
              first_q <= 1'b0;
              last_q  <= 1'b0;
              rowl_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              kc <= kc_n;
              kr <= kr_n;
              ox <= ox_n;
              oy <= oy_n;
              // every lane moves by the same step; lane offsets are constant
              for (int l = 0; l < LANES; l++)
                addr_q[l*ADDR_W +: ADDR_W] <= addr_q[l*ADDR_W +: ADDR_W] + delta;
              first_q <= (kc_n == '0) && (kr_n == '0);
              last_q  <= (kc_n == KW'(K - 1)) && (kr_n == KW'(K - 1));
              rowl_q  <= (ox_n == OXW'(OUT_W - 1));
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_win_addr_gen.sv
// Bench for conv_win_addr_gen: a default conv instance (28x28, K=5, S=1,
// 4 lanes) and a pool instance (24x24, K=2, S=2, 1 lane). Expected taps are
// generated from the closed-form address formula and queued at start; the
// monitors pop and compare on every valid && ready.
module tb_conv_win_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, busy_a, done_a;
  logic rst_b, start_b, busy_b, done_b;

  conv_win_addr_gen_if #(.LANES(4), .ADDR_W(10)) bus_a ();
  conv_win_addr_gen_if #(.LANES(1), .ADDR_W(10)) bus_b ();

  conv_win_addr_gen dut_a (
    .clk(clk), .reset(rst_a), .start(start_a),
    .bus(bus_a.master), .busy(busy_a), .done(done_a)
  );

  conv_win_addr_gen #(
    .IMG_W(24), .IMG_H(24), .K(2), .STRIDE(2), .LANES(1), .ADDR_W(10)
  ) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b),
    .bus(bus_b.master), .busy(busy_b), .done(done_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  typedef struct {
    logic [63:0] addr;
    logic        f, l, r;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  function automatic exp_t make_exp(int t, int iw, int ih, int k, int s, int lanes, int aw);
    exp_t e;
    int ow, rpl, kc, kr, ox, oy;
    ow  = (iw - k) / s + 1;
    rpl = ((ih - k) / s + 1) / lanes;
    kc  = t % k;
    kr  = (t / k) % k;
    ox  = (t / (k * k)) % ow;
    oy  = t / (k * k * ow);
    e.addr = '0;
    for (int l = 0; l < lanes; l++)
      e.addr |= 64'(l * rpl * s * iw + (oy * s + kr) * iw + ox * s + kc) << (l * aw);
    e.f = (kc == 0) && (kr == 0);
    e.l = (kc == k - 1) && (kr == k - 1);
    e.r = (ox == ow - 1);
    return e;
  endfunction

  task automatic push_pass(input bit sel_b);
    if (sel_b) for (int t = 0; t < 576; t++)  qb.push_back(make_exp(t, 24, 24, 2, 2, 1, 10));
    else       for (int t = 0; t < 3600; t++) qa.push_back(make_exp(t, 28, 28, 5, 1, 4, 10));
  endtask

  // ---------------- monitor, conv instance ----------------
  int          a_cnt = 0, a_done_cnt = 0;
  bit          a_stall = 0, a_expdone = 0;
  logic [39:0] a_hold_addr;
  logic [3:0]  a_hold_flg;

  always @(negedge clk) begin
    exp_t e;
    if (rst_a) begin
      qa.delete();
      a_cnt = 0; a_done_cnt = 0; a_stall = 0; a_expdone = 0;
    end else begin
      if (a_expdone) begin
        chk("a_done_latency", done_a, 1);
        a_expdone = 0;
      end
      if (done_a) a_done_cnt++;
      if (a_stall) begin
        chk("a_stall_addr", bus_a.addr, a_hold_addr);
        chk("a_stall_flags", {bus_a.valid, bus_a.tap_first, bus_a.tap_last, bus_a.row_last}, a_hold_flg);
      end
      a_stall = bus_a.valid && !bus_a.ready;
      a_hold_addr = bus_a.addr;
      a_hold_flg  = {bus_a.valid, bus_a.tap_first, bus_a.tap_last, bus_a.row_last};
      if (bus_a.valid && bus_a.ready) begin
        chk("a_queue_nonempty", qa.size() != 0, 1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          chk("a_addr", bus_a.addr, e.addr);
          chk("a_flags", {bus_a.tap_first, bus_a.tap_last, bus_a.row_last}, {e.f, e.l, e.r});
          case (a_cnt)
            0:    chk("a_tap0",    bus_a.addr, {10'd504, 10'd336, 10'd168, 10'd0});
            5:    chk("a_tap5",    bus_a.addr, {10'd532, 10'd364, 10'd196, 10'd28});
            24:   chk("a_tap24",   bus_a.addr, {10'd620, 10'd452, 10'd284, 10'd116});
            25:   chk("a_tap25",   bus_a.addr, {10'd505, 10'd337, 10'd169, 10'd1});
            3599: chk("a_tap3599", bus_a.addr, {10'd783, 10'd615, 10'd447, 10'd279});
            default: ;
          endcase
          if (a_cnt == 24) chk("a_tap24_last", bus_a.tap_last, 1);
          if (qa.size() == 0) a_expdone = 1;
        end
        a_cnt++;
      end
      if (start_a && !busy_a && !done_a) begin
        a_cnt = 0; a_done_cnt = 0;
      end
    end
  end

  // ---------------- monitor, pool instance ----------------
  int b_cnt = 0, b_done_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_b) begin
      qb.delete();
      b_cnt = 0; b_done_cnt = 0;
    end else begin
      if (done_b) b_done_cnt++;
      if (bus_b.valid && bus_b.ready) begin
        chk("b_queue_nonempty", qb.size() != 0, 1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          chk("b_addr", bus_b.addr, e.addr);
          chk("b_flags", {bus_b.tap_first, bus_b.tap_last, bus_b.row_last}, {e.f, e.l, e.r});
          case (b_cnt)
            0:   chk("b_w0_t0", bus_b.addr, 0);
            1:   chk("b_w0_t1", bus_b.addr, 1);
            2:   chk("b_w0_t2", bus_b.addr, 24);
            3:   chk("b_w0_t3", bus_b.addr, 25);
            4:   chk("b_w1_t0", bus_b.addr, 2);
            7:   chk("b_w1_t3", bus_b.addr, 27);
            44:  chk("b_w11_t0", {bus_b.addr, bus_b.row_last}, {10'd22, 1'b1});
            47:  chk("b_w11_t3", {bus_b.addr, bus_b.row_last}, {10'd47, 1'b1});
            575: chk("b_final", bus_b.addr, 575);
            default: ;
          endcase
        end
        b_cnt++;
      end
      if (start_b && !busy_b && !done_b) begin
        b_cnt = 0; b_done_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a_pass();
    push_pass(1'b0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_first_valid", {bus_a.valid, busy_a, bus_a.tap_first}, 3'b111);
  endtask

  task automatic wait_done_a(input int maxc);
    for (int i = 0; i < maxc && !done_a; i++) tick();
    chk("a_done_seen", done_a, 1);
  endtask

  task automatic check_a_pass_end();
    tick();
    chk("a_done_width", done_a, 0);
    chk("a_xfers", a_cnt, 3600);
    chk("a_done_count", a_done_cnt, 1);
    chk("a_queue_drained", qa.size(), 0);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    bus_a.ready = 1'b1; bus_b.ready = 1'b1;
    repeat (3) tick();
    // reset asserted together with start: reset must win
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("a_reset_outs", {bus_a.addr, bus_a.valid, bus_a.tap_first, bus_a.tap_last,
                         bus_a.row_last, busy_a, done_a}, 0);
    chk("b_reset_outs", {bus_b.addr, bus_b.valid, bus_b.tap_first, bus_b.tap_last,
                         bus_b.row_last, busy_b, done_b}, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // pool configuration
    push_pass(1'b1);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 800 && !done_b; i++) tick();
    chk("b_done_seen", done_b, 1);
    tick();
    chk("b_done_width", done_b, 0);
    chk("b_xfers", b_cnt, 576);
    chk("b_done_count", b_done_cnt, 1);

    // pass 1: ready tied high
    start_a_pass();
    wait_done_a(4000);
    check_a_pass_end();

    // pass 2: stall at tap 2, then random ready with stray start pulses
    start_a_pass();
    for (int i = 0; i < 50 && a_cnt != 2; i++) tick();
    chk("a_reach_tap2", a_cnt, 2);
    bus_a.ready = 1'b0;
    repeat (3) tick();
    chk("a_stall_hold", {bus_a.addr, bus_a.valid}, {10'd506, 10'd338, 10'd170, 10'd2, 1'b1});
    chk("a_stall_count", a_cnt, 2);
    bus_a.ready = 1'b1;
    tick();
    chk("a_resume_tap3", bus_a.addr, {10'd507, 10'd339, 10'd171, 10'd3});
    for (int i = 0; i < 20000 && !done_a; i++) begin
      bus_a.ready = 1'($urandom_range(0, 1));
      start_a = (i % 97 == 5);
      tick();
    end
    start_a = 1'b0;
    bus_a.ready = 1'b1;
    chk("a_rand_done_seen", done_a, 1);
    check_a_pass_end();

    // pass 3: back-to-back start, then reset mid-pass at transfer 1000
    start_a_pass();
    for (int i = 0; i < 2000 && a_cnt != 1000; i++) tick();
    chk("a_reach_1000", a_cnt, 1000);
    rst_a = 1'b1;
    tick();
    chk("a_midpass_reset", {bus_a.addr, bus_a.valid, bus_a.tap_first, bus_a.tap_last,
                            bus_a.row_last, busy_a, done_a}, 0);
    rst_a = 1'b0;
    tick();
    chk("a_idle_after_reset", {bus_a.valid, busy_a}, 0);

    // pass 4: fresh pass after the abandoned one
    start_a_pass();
    wait_done_a(4000);
    check_a_pass_end();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
